// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Decode-stage register hazard scoreboard. Each GPR carries a
//             countdown of cycles until its pending result becomes
//             forwardable; the HI/LO multiply/divide unit carries a busy
//             countdown. An instruction in decode stalls when an operand it
//             reads is not ready by the time it consumes it, or when it
//             touches HI/LO while the unit is busy.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TNEW_MAX  largest producer latency accepted on i_id_tnew
//    MULT_CYC  busy cycles of the multiply/divide unit for mult/multu
//    DIV_CYC   busy cycles of the multiply/divide unit for div/divu
//  Ports
//    clk            clock, all state changes on the rising edge
//    reset          synchronous active-high reset
//    i_id_valid     decode holds a real instruction
//    i_id_rs/rt     source register numbers
//    i_id_tuse_rs/rt cycles until operand consumed (3 = not read)
//    i_id_wr_en     instruction writes GPR i_id_wr_addr
//    i_id_tnew      cycles until result forwardable (0 = at issue)
//    i_id_md_start  instruction starts the multiply/divide unit
//    i_id_md_div    selects DIV_CYC instead of MULT_CYC
//    i_id_md_use    instruction touches HI/LO or the md unit
//    o_stall        hold PC and F/D, bubble into E
//    o_issue        instruction advances this cycle
//    o_busy_mask    bit r set while GPR r has a pending result
//    o_md_busy      multiply/divide unit busy
//    o_stall_cnt    stall-cycle counter (only with REG_SCOREBOARD_STAT_EN)
//  Build option
//    REG_SCOREBOARD_STAT_EN  adds the 32-bit wrapping stall counter
// ============================================================================
module reg_scoreboard #(
   parameter int TNEW_MAX = 3,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_id_valid,
   input  logic [4:0]  i_id_rs,
   input  logic [4:0]  i_id_rt,
   input  logic [1:0]  i_id_tuse_rs,
   input  logic [1:0]  i_id_tuse_rt,
   input  logic        i_id_wr_en,
   input  logic [4:0]  i_id_wr_addr,
   input  logic [1:0]  i_id_tnew,
   input  logic        i_id_md_start,
   input  logic        i_id_md_div,
   input  logic        i_id_md_use,
   output logic        o_stall,
   output logic        o_issue,
   output logic [31:0] o_busy_mask,
   output logic        o_md_busy
`ifdef REG_SCOREBOARD_STAT_EN
   ,
   output logic [31:0] o_stall_cnt
`endif
);

   // Timer width covers TNEW_MAX, never narrower than the 2-bit latency
   // input so every presented latency is stored exactly.
   localparam int         c_TW     = ($clog2(TNEW_MAX + 1) > 2) ? $clog2(TNEW_MAX + 1) : 2;
   localparam logic [3:0] c_MULT   = 4'(MULT_CYC);
   localparam logic [3:0] c_DIV    = 4'(DIV_CYC);

   logic [c_TW-1:0] w_timer [32];
   logic [31:0]     w_busy;
   logic            w_rs_stall;
   logic            w_rt_stall;
   logic            w_md_stall;
   logic            w_stall;
   logic            w_issue;
   logic [c_TW-1:0] w_tnew;
   logic            w_wr_timer;
   logic [3:0]      r_md_cnt;

   assign w_tnew     = c_TW'(i_id_tnew);
   // A zero latency result is forwardable at issue, so it never arms a timer.
   assign w_wr_timer = w_issue & i_id_wr_en & (i_id_tnew != 2'd0);

   // $0 never holds a pending result.
   assign w_timer[0] = '0;
   assign w_busy[0]  = 1'b0;

   for (genvar gi = 1; gi < 32; gi++) begin : g_timer
      logic [c_TW-1:0] r_t;
      always_ff @(posedge clk) begin
         if (reset) begin
            r_t <= '0;
         end else if (w_wr_timer && (i_id_wr_addr == 5'(gi))) begin
            // The newest producer wins outright, never a maximum.
            r_t <= w_tnew;
         end else if (r_t != '0) begin
            r_t <= r_t - 1'b1;
         end
      end
      assign w_timer[gi] = r_t;
      assign w_busy[gi]  = (r_t != '0);
   end

   // tuse = 3 means "not read"; a timer can never exceed 3 by default, so
   // no separate read-enable is needed for that case.
   assign w_rs_stall = (i_id_rs != 5'd0) && (w_timer[i_id_rs] > c_TW'(i_id_tuse_rs));
   assign w_rt_stall = (i_id_rt != 5'd0) && (w_timer[i_id_rt] > c_TW'(i_id_tuse_rt));
   assign w_md_stall = i_id_md_use && (r_md_cnt != 4'd0);

   assign w_stall = ~reset & i_id_valid & (w_rs_stall | w_rt_stall | w_md_stall);
   assign w_issue = ~reset & i_id_valid & ~w_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_md_cnt <= 4'd0;
      end else if (w_issue && i_id_md_start) begin
         r_md_cnt <= i_id_md_div ? c_DIV : c_MULT;
      end else if (r_md_cnt != 4'd0) begin
         r_md_cnt <= r_md_cnt - 4'd1;
      end
   end

   assign o_stall     = w_stall;
   assign o_issue     = w_issue;
   assign o_busy_mask = reset ? 32'd0 : w_busy;
   assign o_md_busy   = ~reset & (r_md_cnt != 4'd0);

`ifdef REG_SCOREBOARD_STAT_EN
   logic [31:0] r_stall_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Purpose  : Self-checking bench for reg_scoreboard. A timestamp model
//             (absolute cycle at which each result / the md unit is ready)
//             predicts stall, issue, busy_mask and md_busy every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt;
   logic [1:0]  id_tuse_rs, id_tuse_rt;
   logic        id_wr_en;
   logic [4:0]  id_wr_addr;
   logic [1:0]  id_tnew;
   logic        id_md_start, id_md_div, id_md_use;
   logic        stall, issue, md_busy;
   logic [31:0] busy_mask;
`ifdef REG_SCOREBOARD_STAT_EN
   logic [31:0] stall_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   // model state: absolute cycle at which each register / md unit is free
   int now = 0;
   int ready [32];
   int md_ready = 0;
   longint exp_cnt = 0;

   always #5 clk = ~clk;

   reg_scoreboard #(.TNEW_MAX(3), .MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_id_valid    (id_valid),
      .i_id_rs       (id_rs),
      .i_id_rt       (id_rt),
      .i_id_tuse_rs  (id_tuse_rs),
      .i_id_tuse_rt  (id_tuse_rt),
      .i_id_wr_en    (id_wr_en),
      .i_id_wr_addr  (id_wr_addr),
      .i_id_tnew     (id_tnew),
      .i_id_md_start (id_md_start),
      .i_id_md_div   (id_md_div),
      .i_id_md_use   (id_md_use),
      .o_stall       (stall),
      .o_issue       (issue),
      .o_busy_mask   (busy_mask),
      .o_md_busy     (md_busy)
`ifdef REG_SCOREBOARD_STAT_EN
      ,
      .o_stall_cnt   (stall_cnt)
`endif
   );

   // ---------------- reference model ----------------
   function automatic int m_left(input int r);
      if (r == 0) return 0;
      return (ready[r] > now) ? ready[r] - now : 0;
   endfunction

   function automatic logic m_md_busy();
      return !reset && (md_ready > now);
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m = '0;
      if (reset) return m;
      for (int r = 1; r < 32; r++) m[r] = (m_left(r) > 0);
      return m;
   endfunction

   function automatic logic m_stall();
      if (reset || !id_valid) return 1'b0;
      return (m_left(int'(id_rs)) > int'(id_tuse_rs)) ||
             (m_left(int'(id_rt)) > int'(id_tuse_rt)) ||
             (id_md_use && (md_ready > now));
   endfunction

   function automatic logic m_issue();
      return !reset && id_valid && !m_stall();
   endfunction

   // advance one clock edge, updating the model with what happens at it
   task automatic tick();
      logic st, iss;
      st  = m_stall();
      iss = m_issue();
      @(posedge clk);
      if (reset) begin
         for (int r = 0; r < 32; r++) ready[r] = 0;
         md_ready = 0;
         exp_cnt = 0;
      end else begin
         if (st) exp_cnt = (exp_cnt + 1) % 64'h1_0000_0000;
         if (iss && id_wr_en && id_wr_addr != 0 && id_tnew != 0)
            ready[id_wr_addr] = now + 1 + int'(id_tnew);
         if (iss && id_md_start)
            md_ready = now + 1 + (id_md_div ? 10 : 5);
      end
      now++;
      #1;
   endtask

   task automatic set_instr(input logic v, input int rs, input int turs,
                            input int rt, input int turt, input logic we,
                            input int wa, input int tn, input logic ms,
                            input logic md, input logic mu);
      id_valid = v; id_rs = 5'(rs); id_tuse_rs = 2'(turs);
      id_rt = 5'(rt); id_tuse_rt = 2'(turt); id_wr_en = we;
      id_wr_addr = 5'(wa); id_tnew = 2'(tn);
      id_md_start = ms; id_md_div = md; id_md_use = mu;
   endtask

   task automatic idle();
      set_instr(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      set_instr(1, 8, 0, 9, 0, 1, 8, 3, 1, 1, 1);
      tick(); tick();
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b exp 0", stall); end
      compared++;
      if (issue !== 1'b0) begin mismatched++; $display("FAIL reset_issue: got %b exp 0", issue); end
      compared++;
      if (busy_mask !== 32'd0) begin mismatched++; $display("FAIL reset_mask: got %h exp 0", busy_mask); end
      compared++;
      if (md_busy !== 1'b0) begin mismatched++; $display("FAIL reset_md_busy: got %b exp 0", md_busy); end
      tick();
      reset = 1'b0;
      idle();
      @(negedge clk);
      compared++;
      if (busy_mask !== 32'd0) begin mismatched++; $display("FAIL post_reset_mask: got %h exp 0", busy_mask); end
`ifdef REG_SCOREBOARD_STAT_EN
      compared++;
      if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
`endif
      tick();
   endtask

   // producer, then a consumer held until it issues; every cycle checked
   task automatic producer_consumer(input string tag, input int wa, input int tn,
                                    input int rs, input int tu, input logic md_div_op);
      set_instr(1, 1, 3, 2, 3, wa != 0 || tn != 0, wa, tn, md_div_op, md_div_op, md_div_op);
      @(negedge clk);
      compared++;
      if (issue !== m_issue()) begin mismatched++; $display("FAIL %s producer_issue: got %b exp %b", tag, issue, m_issue()); end
      tick();
      if (md_div_op) set_instr(1, 0, 3, 0, 3, 1, 3, 1, 0, 0, 1);
      else           set_instr(1, rs, tu, 0, 3, 1, 12, 1, 0, 0, 0);
      for (int c = 0; c < 20; c++) begin
         logic done;
         @(negedge clk);
         compared++;
         if (stall !== m_stall() || issue !== m_issue()) begin
            mismatched++;
            $display("FAIL %s cyc%0d stall/issue: got %b/%b exp %b/%b", tag, c, stall, issue, m_stall(), m_issue());
         end
         compared++;
         if (busy_mask !== m_mask() || md_busy !== m_md_busy()) begin
            mismatched++;
            $display("FAIL %s cyc%0d mask/md_busy: got %h/%b exp %h/%b", tag, c, busy_mask, md_busy, m_mask(), m_md_busy());
         end
         done = m_issue();
         tick();
         if (done) break;
         if (c == 19) begin
            compared++; mismatched++;
            $display("FAIL %s timeout: consumer never issued, got stall=%b exp issue", tag, stall);
         end
      end
      idle();
      repeat (12) tick();
   endtask

   task automatic test_load_use();      producer_consumer("load_use", 8, 3, 8, 1, 0); endtask
   task automatic test_branch_alu();    producer_consumer("branch_alu", 9, 2, 9, 0, 0); endtask
   task automatic test_zero_reg();      producer_consumer("zero_reg", 0, 3, 0, 0, 0); endtask
   task automatic test_md_unit();       producer_consumer("md_div", 0, 0, 0, 3, 1); endtask

   task automatic test_override();
      set_instr(1, 1, 3, 2, 3, 1, 5, 3, 0, 0, 0);
      tick();
      set_instr(1, 6, 3, 7, 3, 1, 5, 2, 0, 0, 0);
      @(negedge clk);
      compared++;
      if (issue !== 1'b1) begin mismatched++; $display("FAIL override_issue: got %b exp 1", issue); end
      tick();
      set_instr(1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 8; c++) begin
         logic done;
         @(negedge clk);
         compared++;
         if (stall !== m_stall() || busy_mask !== m_mask()) begin
            mismatched++;
            $display("FAIL override cyc%0d stall/mask: got %b/%h exp %b/%h", c, stall, busy_mask, m_stall(), m_mask());
         end
         done = m_issue();
         tick();
         if (done) break;
      end
      idle();
      repeat (4) tick();
   endtask

   task automatic test_reset_mid_stall();
      set_instr(1, 1, 3, 2, 3, 1, 10, 3, 0, 0, 0);
      tick();
      set_instr(1, 10, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      compared++;
      if (stall !== 1'b1) begin mismatched++; $display("FAIL mid_stall_pre: got %b exp 1", stall); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      compared++;
      if (stall !== 1'b0 || busy_mask !== 32'd0) begin
         mismatched++;
         $display("FAIL mid_stall_after_reset: got stall=%b mask=%h exp 0/0", stall, busy_mask);
      end
`ifdef REG_SCOREBOARD_STAT_EN
      compared++;
      if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL mid_stall_cnt: got %0d exp 0", stall_cnt); end
`endif
      tick();
      idle();
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         logic ms;
         reset = ($urandom_range(0, 79) == 0);
         ms = ($urandom_range(0, 9) == 0);
         set_instr($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 3), ms, $urandom_range(0, 1) != 0,
                   ms | ($urandom_range(0, 7) == 0));
         @(negedge clk);
         compared++;
         if (stall !== m_stall() || issue !== m_issue()) begin
            mismatched++;
            $display("FAIL random cyc%0d stall/issue: got %b/%b exp %b/%b", c, stall, issue, m_stall(), m_issue());
         end
         compared++;
         if (busy_mask !== m_mask() || md_busy !== m_md_busy()) begin
            mismatched++;
            $display("FAIL random cyc%0d mask/md_busy: got %h/%b exp %h/%b", c, busy_mask, md_busy, m_mask(), m_md_busy());
         end
`ifdef REG_SCOREBOARD_STAT_EN
         compared++;
         if (stall_cnt !== 32'(exp_cnt)) begin
            mismatched++;
            $display("FAIL random cyc%0d stall_cnt: got %0d exp %0d", c, stall_cnt, exp_cnt);
         end
`endif
         tick();
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      for (int r = 0; r < 32; r++) ready[r] = 0;
      reset = 1'b1;
      idle();
      #1;
      test_reset();
      test_load_use();
      test_branch_alu();
      test_zero_reg();
      test_md_unit();
      test_override();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
